// File: rtl/btn_conditioner_if.sv
// Button bus between the board pads and the button conditioner.
// master: the side that drives the raw pad levels and consumes the conditioned outputs.
// slave : the conditioner itself.
interface btn_conditioner_if;
  logic [4:0] btn_in;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions the five Basys push-buttons {C,L,U,R,D} = [4:0].
// Each bit has a two-flop synchroniser, a debounce counter and registered
// level / press / release outputs.
// Optional auto-repeat of btn_press is compiled in when the macro
// BTN_AUTO_REPEAT_EN is defined; the default build has no repeat logic.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 100,
  parameter int REPEAT_PERIOD   = 50
) (
  input logic               clk,
  input logic               rst,
  btn_conditioner_if.slave  bus
);

  localparam int NB    = 32'sd5;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 32'sd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'sd0);

  // Reject a parameterisation that would make a counter terminal count negative.
  if (DEBOUNCE_CYCLES < 32'sd1 || REPEAT_DELAY < 32'sd1 || REPEAT_PERIOD < 32'sd1) begin : g_bad_params
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [NB-1:0]    sync1_r;
  logic [NB-1:0]    sync2_r;
  logic [CNT_W-1:0] cnt_r [NB];
  logic [NB-1:0]    level_r;
  logic [NB-1:0]    press_r;
  logic [NB-1:0]    release_r;

  logic [NB-1:0]    rise_s;
  logic [NB-1:0]    fall_s;
  logic [NB-1:0]    rep_fire_s;

  // Terminal-count detection: a bit flips when its synced value has differed long enough.
  always_comb begin
    rise_s = 5'b00000;
    fall_s = 5'b00000;
    for (int i = 32'sd0; i < NB; i++) begin
      if ((sync2_r[i] != level_r[i]) && (cnt_r[i] == CNT_LAST)) begin
        rise_s[i] = sync2_r[i];
        fall_s[i] = ~sync2_r[i];
      end else begin
        rise_s[i] = 1'b0;
        fall_s[i] = 1'b0;
      end
    end
  end

  // Synchroniser, debounce counters and registered level/strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 5'b00000;
      sync2_r   <= 5'b00000;
      level_r   <= 5'b00000;
      press_r   <= 5'b00000;
      release_r <= 5'b00000;
      for (int i = 32'sd0; i < NB; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      sync1_r   <= bus.btn_in;
      sync2_r   <= sync1_r;
      level_r   <= level_r ^ (rise_s | fall_s);
      press_r   <= rise_s | rep_fire_s;
      release_r <= fall_s;
      for (int i = 32'sd0; i < NB; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          // any return to the current level discards the partial count
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 32'sd1);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 32'sd1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 32'sd1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(32'sd1);
  localparam logic [REP_W-1:0] REP_ZERO = REP_W'(32'sd0);

  logic [REP_W-1:0] rep_cnt_r [NB];
  // phase 0: waiting out the initial delay; phase 1: periodic repeats
  logic [NB-1:0]    rep_phase_r;

  // Repeat strobe: only while the level is held and is not falling this edge.
  always_comb begin
    rep_fire_s = 5'b00000;
    for (int i = 32'sd0; i < NB; i++) begin
      if (level_r[i] && !fall_s[i]) begin
        if (rep_phase_r[i]) begin
          rep_fire_s[i] = (rep_cnt_r[i] == PER_LAST);
        end else begin
          rep_fire_s[i] = (rep_cnt_r[i] == DLY_LAST);
        end
      end else begin
        rep_fire_s[i] = 1'b0;
      end
    end
  end

  // Repeat counters: restart on a debounced press, idle while released.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_phase_r <= 5'b00000;
      for (int i = 32'sd0; i < NB; i++) begin
        rep_cnt_r[i] <= REP_ZERO;
      end
    end else begin
      for (int i = 32'sd0; i < NB; i++) begin
        if (rise_s[i] || fall_s[i] || !level_r[i]) begin
          rep_cnt_r[i]   <= REP_ZERO;
          rep_phase_r[i] <= 1'b0;
        end else if (rep_fire_s[i]) begin
          rep_cnt_r[i]   <= REP_ZERO;
          rep_phase_r[i] <= 1'b1;
        end else begin
          rep_cnt_r[i]   <= rep_cnt_r[i] + REP_ONE;
          rep_phase_r[i] <= rep_phase_r[i];
        end
      end
    end
  end
`else
  // Without auto-repeat, btn_press comes only from the debounced rising edge.
  always_comb begin
    rep_fire_s = 5'b00000;
  end
`endif

  assign bus.btn_level   = level_r;
  assign bus.btn_press   = press_r;
  assign bus.btn_release = release_r;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Input-side conditioner for the five Basys push-buttons (C, L, U, R, D), the consumer end of the button stimulus interface.
- Per button: synchronises the raw pad level, debounces it, and emits a clean level plus single-cycle press/release strobes.
- Sits between the board pins and the game/cursor logic in the basys top level.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles a synced input must differ from the current level before the level flips. Legal range >=1. Use 16 in simulation and ~1_000_000 on the board.
- REPEAT_DELAY, 100, cycles from a press strobe to the first auto-repeat strobe. Used only with the optional feature.
- REPEAT_PERIOD, 50, cycles between subsequent auto-repeat strobes. Used only with the optional feature.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  5  raw asynchronous button levels, bit order {C,L,U,R,D} = [4:0].
- btn_level  out  5  debounced level per button.
- btn_press  out  5  one-cycle strobe on each debounced 0->1 (and on auto-repeat if enabled).
- btn_release  out  5  one-cycle strobe on each debounced 1->0.

Behaviour:
- Reset (synchronous, on a clk edge with rst=1):
  - sync flops, counters, btn_level, btn_press and btn_release all clear to 0.
  - rst overrides everything, including a debounce or repeat in progress.
- Synchroniser: two flops per bit, s1 <= btn_in, s2 <= s1. All five bits are independent and identical.
- Debounce counter:
  - width $clog2(DEBOUNCE_CYCLES+1).
  - s2 == btn_level: counter <= 0.
  - s2 != btn_level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != btn_level and counter == DEBOUNCE_CYCLES-1: btn_level <= s2 and counter <= 0. In the same edge the matching strobe is registered: btn_press if s2=1, btn_release if s2=0.
- Latency:
  - Define edge 0 as the first edge where s1 samples the new value.
  - btn_level and the strobe change after edge DEBOUNCE_CYCLES+1.
  - The strobe is high for exactly one cycle.
  - With the default parameters, outputs change 17 edges after edge 0.
- Glitch rejection:
  - Any return of s2 to the current level before the terminal count clears the counter. No strobe, no level change.
  - A pulse shorter than DEBOUNCE_CYCLES cycles never propagates.
- Strobe rules:
  - btn_press and btn_release for the same bit are never high together.
  - Several bits may strobe in the same cycle; no arbitration between buttons.
- No internal state machine beyond per-bit counters. Fully pipelined: one input change per bit is tracked at a time.

Optional Feature:
- Macro BTN_AUTO_REPEAT_EN.
- Defined:
  - A per-bit repeat counter, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1), starts on the press strobe.
  - While btn_level stays 1, btn_press re-pulses for one cycle REPEAT_DELAY cycles after the debounced press, then every REPEAT_PERIOD cycles.
  - The counter clears when btn_level falls and on rst.
  - If a repeat falls on the same cycle the level falls, the repeat is suppressed and only btn_release fires.
- Undefined: repeat logic is not elaborated and btn_press fires once per debounced press.

Test Plan:
- rst=1 for 3 cycles with btn_in=5'b11111 -> all outputs 0 throughout and 0 on the first cycle after rst deasserts.
- btn_in[0] (D) high for 400 cycles, then low; DEBOUNCE_CYCLES=16 ->
  - btn_press[0] one-cycle pulse after edge 17.
  - btn_level[0] high from edge 17 to edge 417.
  - btn_release[0] pulse after edge 417.
  - No other bits move.
- Bounce: btn_in[2] toggles every 3 cycles for 30 cycles, then settles high -> no strobe during the bounce; a single btn_press[2] 17 edges after the final rising sample.
- btn_in = 5'b10010 (C and R) rising in the same cycle -> btn_press = 5'b10010 in one single cycle, btn_level = 5'b10010.
- Reset mid-count: btn_in[3] high, rst asserted at count 10 for 1 cycle ->
  - counter restarts from 0.
  - btn_press[3] appears 17 edges after the reset cycle, not earlier.
- BTN_AUTO_REPEAT_EN, DELAY=100, PERIOD=50, btn_in[1] held 400 cycles ->
  - btn_press[1] pulses at edges 17, 117, 167, 217, 267, 317, 367 (7 total).
  - Nothing at 417, where only btn_release[1] fires.
